trace_dump_ctrl: RTL and testbench

//  Gates capture into the circular trace buffer and sequences its readout port.

---
 rtl/trace_dump_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_trace_dump_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_dump_ctrl.sv
// Generic synchronous FIFO with registered storage and an occupancy count.
// Latency: a pushed entry appears at out_dat on the cycle after the push.
// Backpressure: pops only on out_vld & out_rdy; pushing into a full FIFO is the caller's error.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    input  logic [W-1:0]  in_dat,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [W-1:0]  out_dat,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign out_vld = (count != '0);
    assign out_dat = mem[rd_ptr];
    assign pop     = out_vld & out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (in_vld) begin
                mem[wr_ptr] <= in_dat;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            case ({in_vld, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Gates trace capture and streams the newest buffer entries, oldest first, to the host.
// Latency: dump_req at edge E0 gives first dump_valid after edge E0+RAM_LATENCY+2.
// Backpressure: reads issue against skid FIFO credit; entries hold stable while dump_ready is low.
module trace_dump_ctrl #(
    parameter int N           = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int TB_SIZE     = 64,
    parameter int RAM_LATENCY = 1,
    localparam int AW         = $clog2(TB_SIZE)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           trace_en,
    input  logic                           valid_in,
    input  logic                           dump_req,
    output logic                           tracing,
    output logic [AW-1:0]                  rd_addr,
    input  logic [N-1:0][DATA_WIDTH-1:0]   rd_vector,
    output logic                           dump_valid,
    input  logic                           dump_ready,
    output logic [N-1:0][DATA_WIDTH-1:0]   dump_vector,
    output logic                           dump_last,
    output logic                           dump_done,
    output logic                           busy
);
    localparam int DEPTH = RAM_LATENCY + 1;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FREEZE, READ, DONE} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          fill;
    logic [AW-1:0]          remaining;
    logic [RAM_LATENCY-1:0] pipe;
    logic [CW-1:0]          inflight;
    logic [CW-1:0]          fifo_count;
    logic [CW:0]            credit_used;
    logic                   issue;
    logic                   capture;
    logic                   pop;
    logic                   last_accept;
    logic                   tracing_d;
    logic                   dump_done_d;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RAM_LATENCY; i++) inflight = inflight + CW'(pipe[i]);
    end

    assign pop     = dump_valid & dump_ready;
    assign capture = pipe[RAM_LATENCY-1];

    // Counting the same-cycle pop as freed credit keeps one beat per cycle with ready held high.
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight} - {{CW{1'b0}}, pop};
    assign issue       = (state_q == READ) && (remaining != '0)
                         && (credit_used < (CW+1)'(RAM_LATENCY + 1));

    assign dump_last   = (state_q == READ) && dump_valid && (remaining == '0)
                         && (inflight == '0) && (fifo_count == CW'(1));
    assign last_accept = dump_last & dump_ready;
    assign busy        = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        tracing_d   = 1'b0;
        dump_done_d = last_accept;
        case (state_q)
            IDLE: begin
                tracing_d = trace_en;
                if (dump_req) begin
                    if (fill != '0) begin
                        state_d   = FREEZE;
                        tracing_d = 1'b0;
                    end else begin
                        dump_done_d = 1'b1;
                    end
                end
            end
            FREEZE:  state_d = READ;
            READ:    if (last_accept) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tracing   <= 1'b0;
            dump_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            tracing   <= tracing_d;
            dump_done <= dump_done_d;
        end
    end

    // Shadow of the buffer's write pointer; wr_ptr resets to the buffer's power-up address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= AW'(1);
            fill   <= '0;
        end else if (state_q == DONE) begin
            fill <= '0;
        end else if (tracing && valid_in) begin
            wr_ptr <= (wr_ptr == AW'(TB_SIZE - 1)) ? '0 : wr_ptr + AW'(1);
            if (fill != AW'(TB_SIZE - 1)) fill <= fill + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr   <= '0;
            remaining <= '0;
        end else if (state_q == FREEZE) begin
            rd_addr   <= wr_ptr - fill;
            remaining <= fill;
        end else if (issue) begin
            rd_addr   <= rd_addr + AW'(1);
            remaining <= remaining - AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe[0] <= issue;
            for (int i = 1; i < RAM_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    fifo #(
        .W     (N * DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (capture),
        .in_dat  (rd_vector),
        .out_vld (dump_valid),
        .out_rdy (dump_ready),
        .out_dat (dump_vector),
        .count   (fifo_count)
    );
endmodule

// File: tb/tb_trace_dump_ctrl.sv
// Directed bench for trace_dump_ctrl with a small behavioural trace buffer.
// Each task drives one scenario and checks its own results inline.
module tb_trace_dump_ctrl;
    typedef logic [7:0][31:0] vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trace_en = 1'b0;
    logic       valid_in = 1'b0;
    logic       dump_req = 1'b0;
    logic       tracing;
    logic [2:0] rd_addr;
    vec_t       rd_vector;
    logic       dump_valid;
    logic       dump_ready = 1'b0;
    vec_t       dump_vector;
    logic       dump_last;
    logic       dump_done;
    logic       busy;

    vec_t       vin = '0;
    vec_t       bmem [8];
    logic [2:0] bptr;
    logic       model_clr = 1'b1;

    int tests = 0;
    int fails = 0;

    trace_dump_ctrl #(.N(8), .DATA_WIDTH(32), .TB_SIZE(8), .RAM_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n), .trace_en(trace_en), .valid_in(valid_in),
        .dump_req(dump_req), .tracing(tracing), .rd_addr(rd_addr), .rd_vector(rd_vector),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_vector(dump_vector),
        .dump_last(dump_last), .dump_done(dump_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Trace buffer model: powers up writing at address 1, one-cycle port-B read.
    always @(posedge clk) begin
        if (model_clr) begin
            bptr <= 3'd1;
            for (int i = 0; i < 8; i++) bmem[i] <= '0;
        end else if (tracing && valid_in) begin
            bmem[bptr] <= vin;
            bptr       <= bptr + 3'd1;
        end
        rd_vector <= bmem[rd_addr];
    end

    function automatic vec_t exp_vec(input int k);
        vec_t v;
        for (int i = 0; i < 8; i++) v[i] = {8'(i), 24'(k)};
        return v;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; model_clr = 1'b1; trace_en = 1'b1;
        valid_in = 1'b0; dump_req = 1'b0; dump_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1; model_clr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic trace_vectors(input int first, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            valid_in = 1'b1;
            vin      = exp_vec(first + k);
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic run_dump(input string name, input int n, input int first, input int start,
                            input bit alt_ready, input int req_again, input bit vin_during);
        int   beats = 0, first_valid = -1, last_hs = -1, done_cyc = -1, done_cnt = 0;
        bit   prev_stall = 1'b0, prev_last = 1'b0;
        vec_t prev_vec = '0;
        @(posedge clk); #1;
        dump_req = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            dump_req   = (cyc == req_again);
            dump_ready = alt_ready ? (cyc % 2 == 0) : 1'b1;
            valid_in   = vin_during && (cyc <= 7);
            vin        = exp_vec(99);
            @(negedge clk);
            if (!alt_ready && cyc >= 1 && cyc <= n) begin
                tests++;
                if (rd_addr !== 3'(start + cyc - 1))
                    $display("FAIL %s rd_addr cyc%0d: got %0d want %0d", name, cyc, rd_addr, 3'(start + cyc - 1));
                if (rd_addr !== 3'(start + cyc - 1)) fails++;
            end
            if (prev_stall) begin
                tests++;
                if (dump_valid !== 1'b1 || dump_vector !== prev_vec || dump_last !== prev_last) begin
                    fails++;
                    $display("FAIL %s stall_stable cyc%0d: got v=%0b %0h want v=1 %0h", name, cyc, dump_valid, dump_vector, prev_vec);
                end
            end
            if (dump_valid === 1'b1 && first_valid < 0) first_valid = cyc;
            if (dump_valid === 1'b1 && dump_ready) begin
                tests++;
                if (dump_vector !== exp_vec(first + beats)) begin
                    fails++;
                    $display("FAIL %s beat%0d data: got %0h want %0h", name, beats, dump_vector, exp_vec(first + beats));
                end
                tests++;
                if (dump_last !== (beats == n - 1)) begin
                    fails++;
                    $display("FAIL %s beat%0d last: got %0b want %0b", name, beats, dump_last, beats == n - 1);
                end
                beats++;
                last_hs = cyc;
            end
            if (dump_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = (dump_valid === 1'b1) && !dump_ready;
            prev_vec   = dump_vector;
            prev_last  = dump_last;
        end
        valid_in = 1'b0;
        tests++;
        if (beats != n) begin fails++; $display("FAIL %s beat_count: got %0d want %0d", name, beats, n); end
        tests++;
        if (first_valid != 3) begin fails++; $display("FAIL %s first_valid_cyc: got %0d want 3", name, first_valid); end
        tests++;
        if (done_cnt != 1 || done_cyc != last_hs + 1) begin
            fails++;
            $display("FAIL %s dump_done: got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", name, done_cnt, done_cyc, last_hs + 1);
        end
        if (!alt_ready) begin
            tests++;
            if (last_hs != first_valid + n - 1) begin
                fails++;
                $display("FAIL %s back_to_back: got last_cyc=%0d want %0d", name, last_hs, first_valid + n - 1);
            end
        end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL %s busy_after: got %0b want 0", name, busy); end
    endtask

    task automatic test_empty_dump(input string name);
        @(posedge clk); #1;
        dump_req = 1'b1;
        @(posedge clk); #1;
        dump_req = 1'b0;
        @(negedge clk);
        tests++;
        if (dump_done !== 1'b1 || busy !== 1'b0 || dump_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s pulse: got done=%0b busy=%0b valid=%0b want 1 0 0", name, dump_done, busy, dump_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (dump_done !== 1'b0 || dump_valid !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL %s quiet%0d: got done=%0b valid=%0b busy=%0b want 0 0 0", name, i, dump_done, dump_valid, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; model_clr = 1'b1; trace_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({tracing, rd_addr, dump_valid, dump_last, dump_done, busy} !== 8'd0 || dump_vector !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got tr=%0b addr=%0d v=%0b l=%0b d=%0b b=%0b want all 0",
                     tracing, rd_addr, dump_valid, dump_last, dump_done, busy);
        end
        @(posedge clk); #1 rst_n = 1'b1; model_clr = 1'b0;
        @(negedge clk);
        tests++;
        if (tracing !== 1'b0) begin fails++; $display("FAIL tracing_at_release: got %0b want 0", tracing); end
        @(negedge clk);
        tests++;
        if (tracing !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL tracing_after_release: got tr=%0b busy=%0b want 1 0", tracing, busy);
        end
    endtask

    task automatic test_basic_dump();
        do_reset();
        trace_vectors(1, 5);
        run_dump("basic", 5, 1, 1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_ignored_inputs();
        // wr_ptr=6 from the previous dump: vectors 21..25 land at 6,7,0,1,2
        trace_vectors(21, 5);
        run_dump("ignored", 5, 21, 6, 1'b0, 4, 1'b1);
        trace_vectors(26, 2);
        run_dump("ptr_frozen", 2, 26, 3, 1'b0, -1, 1'b0);
        test_empty_dump("empty");
    endtask

    task automatic test_wrap();
        do_reset();
        trace_vectors(1, 20);
        run_dump("wrap", 7, 14, 6, 1'b0, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        do_reset();
        trace_vectors(1, 5);
        run_dump("backpressure", 5, 1, 1, 1'b1, -1, 1'b0);
    endtask

    task automatic test_reset_mid_dump();
        do_reset();
        trace_vectors(1, 5);
        @(posedge clk); #1;
        dump_req = 1'b1;
        @(posedge clk); #1;
        dump_req = 1'b0; dump_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        tests++;
        if (dump_valid !== 1'b1 || dump_vector !== exp_vec(3)) begin
            fails++;
            $display("FAIL midreset_beat3: got v=%0b %0h want v=1 %0h", dump_valid, dump_vector, exp_vec(3));
        end
        rst_n = 1'b0; model_clr = 1'b1;
        #1;
        tests++;
        if ({tracing, rd_addr, dump_valid, dump_last, dump_done, busy} !== 8'd0 || dump_vector !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: got tr=%0b addr=%0d v=%0b l=%0b d=%0b b=%0b want all 0",
                     tracing, rd_addr, dump_valid, dump_last, dump_done, busy);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; model_clr = 1'b0; dump_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || dump_valid !== 1'b0) begin
            fails++;
            $display("FAIL midreset_idle: got busy=%0b valid=%0b want 0 0", busy, dump_valid);
        end
        test_empty_dump("midreset_fill0");
    endtask

    initial begin
        test_reset();
        test_basic_dump();
        test_ignored_inputs();
        test_wrap();
        test_backpressure();
        test_reset_mid_dump();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
